mac_seq_unit: RTL and testbench

Parametrised sequential multiply-accumulate engine with a control FSM. It computes a dot product of `len` operand pairs streamed through a valid/ready handshake. It generalises the fixed 2-bit/8-bit MAC-with-FSM with configurable widths, signed mode, saturation, overflow flagging and a programmable term count. It sits between an operand source (memory reader or testbench) and a result consumer that samples `out` on `done`.

---
 rtl/mac_seq_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mac_seq_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_unit.sv
// -----------------------------------------------------------------------------
// mac_seq_unit
//
// Sequential multiply-accumulate engine. A start pulse in IDLE captures a term
// count, then `len` operand pairs are accepted over a valid/ready handshake and
// their products are summed into a registered accumulator. A one-cycle `done`
// pulse marks the final result, which stays on `out` until the next start.
//
// Arithmetic is signed or unsigned (SIGNED). On overflow the sum either
// saturates to the nearest bound (SATURATE=1) or wraps modulo 2^ACC_WIDTH.
// In both modes `overflow` is sticky until the next start or reset.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   start     in   begin a dot product (acts only in IDLE)
//   len       in   number of products, captured with start
//   in_valid  in   a/b pair valid this cycle
//   in_ready  out  pair accepted this cycle (high in ACCUM, combinational)
//   a, b      in   operands
//   out       out  accumulator value (registered)
//   busy      out  high in ACCUM and DONE (registered)
//   done      out  one-cycle result pulse (registered)
//   overflow  out  sticky range-overflow flag (registered)
// -----------------------------------------------------------------------------
module mac_seq_unit #(
  parameter int DATA_WIDTH = 2,
  parameter int ACC_WIDTH  = 8,
  parameter int LEN_WIDTH  = 4,
  parameter bit SIGNED     = 1'b0,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int EXT_WIDTH  = ACC_WIDTH + 1;
  localparam int PAD_WIDTH  = EXT_WIDTH - PROD_WIDTH;

  // The extended sum must hold any product plus any accumulator value.
  if (ACC_WIDTH < PROD_WIDTH) begin : g_width_check
    $error("mac_seq_unit: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  logic [ACC_WIDTH-1:0]   out_q;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   overflow_q;

  // ---------------------------------------------------------------------------
  // Datapath: product, extended sum, range check, clamp/wrap
  // ---------------------------------------------------------------------------
  logic [PROD_WIDTH-1:0]  prod;
  logic [EXT_WIDTH-1:0]   prod_ext;
  logic [EXT_WIDTH-1:0]   acc_ext;
  logic [EXT_WIDTH-1:0]   sum_ext;
  logic                   range_err;
  logic [ACC_WIDTH-1:0]   acc_d;
  logic                   ovf_d;

  localparam logic [ACC_WIDTH-1:0] U_MAX = {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] S_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] S_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    prod      = '0;
    prod_ext  = '0;
    acc_ext   = '0;
    sum_ext   = '0;
    range_err = 1'b0;
    acc_d     = out_q;
    ovf_d     = 1'b0;

    if (SIGNED) begin
      // A signed product of two DATA_WIDTH operands always fits PROD_WIDTH.
      prod     = PROD_WIDTH'($signed(a) * $signed(b));
      prod_ext = {{PAD_WIDTH{prod[PROD_WIDTH-1]}}, prod};
      acc_ext  = {out_q[ACC_WIDTH-1], out_q};
      sum_ext  = prod_ext + acc_ext;
      // The extra top bit disagreeing with the result sign means the true
      // sum is outside the signed range.
      range_err = sum_ext[EXT_WIDTH-1] ^ sum_ext[ACC_WIDTH-1];
    end else begin
      prod     = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
      prod_ext = {{PAD_WIDTH{1'b0}}, prod};
      acc_ext  = {1'b0, out_q};
      sum_ext  = prod_ext + acc_ext;
      // Products are non-negative, so only the upper bound can be crossed.
      range_err = sum_ext[EXT_WIDTH-1];
    end

    ovf_d = range_err;
    if (range_err && SATURATE) begin
      if (SIGNED) begin
        // Bit ACC_WIDTH of the extended sum is the true sign of the result.
        acc_d = sum_ext[EXT_WIDTH-1] ? S_MIN : S_MAX;
      end else begin
        acc_d = U_MAX;
      end
    end else begin
      acc_d = sum_ext[ACC_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: every register here is a control or datapath flop with a defined
  // reset value; there is no memory array that would need to go unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          // Any in_valid seen here is ignored: pairs are only taken in ACCUM.
          if (start) begin
            out_q       <= '0;
            overflow_q  <= 1'b0;
            remaining_q <= len;
            busy_q      <= 1'b1;
            if (len != '0) begin
              state_q <= S_ACCUM;
            end else begin
              // Empty dot product: report a zero result straight away.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_ACCUM: begin
          // in_ready is high throughout ACCUM, so in_valid alone is an accept.
          if (in_valid) begin
            out_q       <= acc_d;
            overflow_q  <= overflow_q | ovf_d;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Result holds on out until the next start.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready = (state_q == S_ACCUM);
  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mac_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_mac_seq_unit
//
// Five instances of mac_seq_unit share one operand stream:
//   0: default            (8-bit acc, unsigned, saturate)
//   1: 5-bit acc, unsigned, saturate
//   2: 5-bit acc, unsigned, wrap
//   3: 4-bit acc, signed,   saturate
//   4: 4-bit acc, signed,   wrap
// A table of hand-computed vectors is applied first, then hand-written reset
// sequences, then random transactions checked against an integer model.
// -----------------------------------------------------------------------------
module tb_mac_seq_unit;

  localparam int NCFG = 5;
  localparam int ACC_W [NCFG] = '{8, 5, 5, 4, 4};
  localparam bit SGN   [NCFG] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit SAT   [NCFG] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  typedef int arr5_t  [NCFG];
  typedef bit barr5_t [NCFG];
  typedef int arr16_t [16];

  typedef struct {
    int     n;
    int     a [5];
    int     b [5];
    int     stall;   // idle cycles before each pair after the first; -1 = random
    bit     noise;   // drive stray start / in_valid where they must be ignored
    arr5_t  eo;
    barr5_t eov;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;

  logic [7:0] out0;
  logic [4:0] out1;
  logic [4:0] out2;
  logic [3:0] out3;
  logic [3:0] out4;
  logic [4:0] rdy_v;
  logic [4:0] busy_v;
  logic [4:0] done_v;
  logic [4:0] ovf_v;
  int         o_val [NCFG];

  int n_checks = 0;
  int n_errors = 0;

  mac_seq_unit #(.DATA_WIDTH(2), .ACC_WIDTH(8), .LEN_WIDTH(4), .SIGNED(1'b0), .SATURATE(1'b1)) u0 (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy_v[0]), .a(a), .b(b), .out(out0), .busy(busy_v[0]),
    .done(done_v[0]), .overflow(ovf_v[0]));
  mac_seq_unit #(.DATA_WIDTH(2), .ACC_WIDTH(5), .LEN_WIDTH(4), .SIGNED(1'b0), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy_v[1]), .a(a), .b(b), .out(out1), .busy(busy_v[1]),
    .done(done_v[1]), .overflow(ovf_v[1]));
  mac_seq_unit #(.DATA_WIDTH(2), .ACC_WIDTH(5), .LEN_WIDTH(4), .SIGNED(1'b0), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy_v[2]), .a(a), .b(b), .out(out2), .busy(busy_v[2]),
    .done(done_v[2]), .overflow(ovf_v[2]));
  mac_seq_unit #(.DATA_WIDTH(2), .ACC_WIDTH(4), .LEN_WIDTH(4), .SIGNED(1'b1), .SATURATE(1'b1)) u3 (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy_v[3]), .a(a), .b(b), .out(out3), .busy(busy_v[3]),
    .done(done_v[3]), .overflow(ovf_v[3]));
  mac_seq_unit #(.DATA_WIDTH(2), .ACC_WIDTH(4), .LEN_WIDTH(4), .SIGNED(1'b1), .SATURATE(1'b0)) u4 (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy_v[4]), .a(a), .b(b), .out(out4), .busy(busy_v[4]),
    .done(done_v[4]), .overflow(ovf_v[4]));

  always_comb begin
    o_val[0] = int'(out0);
    o_val[1] = int'(out1);
    o_val[2] = int'(out2);
    o_val[3] = int'($signed(out3));
    o_val[4] = int'($signed(out4));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (n_checks=%0d n_errors=%0d)", n_checks, n_errors);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input bit edone, input bit ebusy, input bit erdy);
    check({tag, " done"},     int'(done_v), edone ? 31 : 0);
    check({tag, " busy"},     int'(busy_v), ebusy ? 31 : 0);
    check({tag, " in_ready"}, int'(rdy_v),  erdy  ? 31 : 0);
  endtask

  task automatic check_res(input string tag, input arr5_t eo, input barr5_t eov);
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("%s out[%0d]", tag, c), o_val[c], eo[c]);
      check($sformatf("%s overflow[%0d]", tag, c), int'(ovf_v[c]), int'(eov[c]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the true mathematical sum.
  // ---------------------------------------------------------------------------
  function automatic int as_operand(input int raw, input bit sgn);
    return (sgn && raw >= 2) ? raw - 4 : raw;
  endfunction

  function automatic void model(input int n, input arr16_t av, input arr16_t bv,
                                output arr5_t eo, output barr5_t eov);
    for (int c = 0; c < NCFG; c++) begin
      int acc = 0;
      bit ov  = 1'b0;
      int m   = 1 << ACC_W[c];
      int hi  = SGN[c] ? (m / 2) - 1 : m - 1;
      int lo  = SGN[c] ? -(m / 2) : 0;
      for (int i = 0; i < n; i++) begin
        int sum = acc + as_operand(av[i], SGN[c]) * as_operand(bv[i], SGN[c]);
        if (sum > hi || sum < lo) begin
          ov = 1'b1;
          if (SAT[c]) begin
            sum = (sum > hi) ? hi : lo;
          end else begin
            sum = ((sum % m) + m) % m;
            if (SGN[c] && sum > hi) sum = sum - m;
          end
        end
        acc = sum;
      end
      eo[c]  = acc;
      eov[c] = ov;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // One full transaction: start, n accepts (with optional stalls), DONE, IDLE.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input string tag, input int n, input arr16_t av, input arr16_t bv,
                         input int stall, input bit noise, input arr5_t eo, input barr5_t eov);
    arr5_t  zero_o = '{0, 0, 0, 0, 0};
    barr5_t zero_v = '{0, 0, 0, 0, 0};
    @(posedge clk); #1;
    start    = 1'b1;
    len      = 4'(n);
    // A pair presented together with start must not be consumed.
    in_valid = noise;
    a        = 2'd3;
    b        = 2'd3;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    if (n > 0) begin
      check_ctl({tag, " enter"}, 1'b0, 1'b1, 1'b1);
      check_res({tag, " enter"}, zero_o, zero_v);
    end
    for (int i = 0; i < n; i++) begin
      int ns = (i == 0) ? 0 : ((stall < 0) ? int'($urandom_range(0, 2)) : stall);
      for (int s = 0; s < ns; s++) begin
        int snap = o_val[0];
        in_valid = 1'b0;
        if (noise) begin
          start = 1'b1;
          len   = 4'($urandom_range(1, 15));
        end
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("%s stall%0d out", tag, i), o_val[0], snap);
        check($sformatf("%s stall%0d done", tag, i), int'(done_v), 0);
        check($sformatf("%s stall%0d in_ready", tag, i), int'(rdy_v), 31);
      end
      in_valid = 1'b1;
      a        = 2'(av[i]);
      b        = 2'(bv[i]);
      check($sformatf("%s accept%0d in_ready", tag, i), int'(rdy_v), 31);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < n - 1) check($sformatf("%s accept%0d done", tag, i), int'(done_v), 0);
    end
    check_ctl({tag, " DONE"}, 1'b1, 1'b1, 1'b0);
    check_res({tag, " DONE"}, eo, eov);
    @(posedge clk); #1;
    check_ctl({tag, " after"}, 1'b0, 1'b0, 1'b0);
    check({tag, " hold out"}, o_val[NCFG-1], eo[NCFG-1]);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t vecs [9];

  initial begin
    arr16_t av;
    arr16_t bv;
    arr5_t  eo;
    barr5_t eov;
    arr5_t  zero_o = '{0, 0, 0, 0, 0};
    barr5_t zero_v = '{0, 0, 0, 0, 0};

    vecs[0] = '{3, '{1, 2, 3, 0, 0}, '{1, 2, 3, 0, 0},  0, 1'b0, '{14, 14, 14,  6,  6}, '{0, 0, 0, 0, 0}};
    vecs[1] = '{3, '{1, 2, 3, 0, 0}, '{1, 2, 3, 0, 0},  2, 1'b0, '{14, 14, 14,  6,  6}, '{0, 0, 0, 0, 0}};
    vecs[2] = '{4, '{3, 3, 3, 3, 0}, '{3, 3, 3, 3, 0},  0, 1'b0, '{36, 31,  4,  4,  4}, '{0, 1, 1, 0, 0}};
    vecs[3] = '{2, '{2, 1, 0, 0, 0}, '{2, 2, 0, 0, 0},  0, 1'b0, '{ 6,  6,  6,  2,  2}, '{0, 0, 0, 0, 0}};
    vecs[4] = '{3, '{2, 2, 2, 0, 0}, '{2, 2, 2, 0, 0},  0, 1'b0, '{12, 12, 12,  7, -4}, '{0, 0, 0, 1, 1}};
    vecs[5] = '{0, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0},  0, 1'b1, '{ 0,  0,  0,  0,  0}, '{0, 0, 0, 0, 0}};
    vecs[6] = '{5, '{2, 2, 2, 2, 2}, '{1, 1, 1, 1, 1},  0, 1'b0, '{10, 10, 10, -8,  6}, '{0, 0, 0, 1, 1}};
    vecs[7] = '{3, '{2, 2, 1, 0, 0}, '{2, 2, 2, 0, 0},  1, 1'b1, '{10, 10, 10,  5,  6}, '{0, 0, 0, 1, 1}};
    vecs[8] = '{5, '{3, 3, 3, 3, 3}, '{3, 3, 3, 3, 3},  0, 1'b1, '{45, 31, 13,  5,  5}, '{0, 1, 1, 0, 0}};

    reset    = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    // Reset state, before any clock edge.
    #2;
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_res("reset", zero_o, zero_v);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Table-driven vectors.
    for (int v = 0; v < 9; v++) begin
      av = '{default: 0};
      bv = '{default: 0};
      for (int i = 0; i < 5; i++) begin
        av[i] = vecs[v].a[i];
        bv[i] = vecs[v].b[i];
      end
      run_txn($sformatf("vec%0d", v), vecs[v].n, av, bv, vecs[v].stall, vecs[v].noise,
              vecs[v].eo, vecs[v].eov);
    end

    // Reset mid-operation: len=5, two accepts of (-2,-2) leave the signed
    // saturating instance clamped at 7 with overflow set, then reset aborts.
    @(posedge clk); #1;
    start = 1'b1;
    len   = 4'd5;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    a        = 2'd2;
    b        = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre-reset out[3]", o_val[3], 7);
    check("pre-reset overflow[3]", int'(ovf_v[3]), 1);
    check("pre-reset out[0]", o_val[0], 8);
    #2 reset = 1'b0;
    #1;
    check_ctl("async reset", 1'b0, 1'b0, 1'b0);
    check_res("async reset", zero_o, zero_v);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    begin
      int seen_done = 0;
      int seen_rdy  = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (done_v != '0) seen_done++;
        if (rdy_v != '0) seen_rdy++;
      end
      check("post-reset done pulses", seen_done, 0);
      check("post-reset in_ready cycles", seen_rdy, 0);
    end

    // Randomised transactions against the model.
    for (int t = 0; t < 40; t++) begin
      int n = (t % 8 == 0) ? 0 : int'($urandom_range(1, 15));
      av = '{default: 0};
      bv = '{default: 0};
      for (int i = 0; i < n; i++) begin
        av[i] = int'($urandom_range(0, 3));
        bv[i] = int'($urandom_range(0, 3));
      end
      model(n, av, bv, eo, eov);
      run_txn($sformatf("rand%0d", t), n, av, bv, -1, 1'($urandom_range(0, 1)), eo, eov);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
